// File: rtl/usb_phy_rx.sv
// Full-speed USB receive front end: synchronizer, 4x DPLL, NRZI decode, SYNC/unstuff/EOP, byte assembly.
// Optional bus reset detector built when USB_RX_BUS_RESET_EN is defined.
module usb_phy_rx #(
  parameter int RESET_CYC      = 120,
  parameter int SYNC_MIN_ZEROS = 3
) (
  input  logic       clk_48m,
  input  logic       rst_n,
  input  logic       usb_dp_rx,
  input  logic       usb_dn_rx,
  input  logic       rx_en,
  output logic [1:0] line_state,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       bus_reset
);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;
  localparam logic [2:0] SYNC_MIN = 3'(SYNC_MIN_ZEROS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ERR
  } state_t;

  logic [1:0] meta_reg, line_state_reg, prev_level_reg;
  logic [1:0] phase_reg;
  logic       jk_edge, sample, decoded;

  state_t     state_reg, state_next;
  logic [2:0] zero_cnt_reg, zero_cnt_next;
  logic [2:0] ones_cnt_reg, ones_cnt_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] byte_reg, byte_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       rx_err_reg, rx_err_next;
  logic       rx_active_reg, rx_active_next;
  logic       se0_seen_reg, se0_seen_next;

  // Phase is cleared on the same edge that line_state takes a new J/K level,
  // so the sample strobe lands two cycles into each bit cell.
  assign jk_edge = (meta_reg != line_state_reg) && (meta_reg[1] ^ meta_reg[0]) &&
                   (line_state_reg[1] ^ line_state_reg[0]);
  assign sample  = (phase_reg == 2'd2);
  assign decoded = (line_state_reg == prev_level_reg);

  always_ff @(posedge clk_48m) begin
    if (!rst_n) begin
      meta_reg       <= LS_SE0;
      line_state_reg <= LS_SE0;
      phase_reg      <= 2'd0;
      prev_level_reg <= LS_J;
    end else begin
      meta_reg       <= {usb_dp_rx, usb_dn_rx};
      line_state_reg <= meta_reg;
      phase_reg      <= jk_edge ? 2'd0 : phase_reg + 2'd1;
      if (sample) begin
        prev_level_reg <= line_state_reg;
      end
    end
  end

  always_ff @(posedge clk_48m) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      zero_cnt_reg  <= 3'd0;
      ones_cnt_reg  <= 3'd0;
      bit_cnt_reg   <= 3'd0;
      byte_reg      <= 8'h00;
      rx_data_reg   <= 8'h00;
      rx_valid_reg  <= 1'b0;
      rx_err_reg    <= 1'b0;
      rx_active_reg <= 1'b0;
      se0_seen_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      zero_cnt_reg  <= zero_cnt_next;
      ones_cnt_reg  <= ones_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      byte_reg      <= byte_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      rx_err_reg    <= rx_err_next;
      rx_active_reg <= rx_active_next;
      se0_seen_reg  <= se0_seen_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    zero_cnt_next  = zero_cnt_reg;
    ones_cnt_next  = ones_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    byte_next      = byte_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    rx_err_next    = 1'b0;
    rx_active_next = rx_active_reg;
    se0_seen_next  = se0_seen_reg;

    if (!rx_en) begin
      state_next     = ST_IDLE;
      rx_active_next = 1'b0;
    end else if (sample) begin
      case (state_reg)
        ST_IDLE: begin
          if (line_state_reg == LS_K) begin
            state_next    = ST_SYNC;
            zero_cnt_next = 3'd1;
          end
        end
        ST_SYNC: begin
          if (line_state_reg == LS_SE0 || line_state_reg == LS_SE1) begin
            state_next = ST_IDLE;
          end else if (!decoded) begin
            zero_cnt_next = (zero_cnt_reg == 3'd7) ? 3'd7 : zero_cnt_reg + 3'd1;
          end else if (zero_cnt_reg >= SYNC_MIN) begin
            state_next     = ST_DATA;
            rx_active_next = 1'b1;
            bit_cnt_next   = 3'd0;
            ones_cnt_next  = 3'd0;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (line_state_reg == LS_SE0) begin
            state_next  = ST_EOP;
            rx_err_next = (bit_cnt_reg != 3'd0);
          end else if (line_state_reg == LS_SE1) begin
            state_next    = ST_ERR;
            rx_err_next   = 1'b1;
            se0_seen_next = 1'b0;
          end else if (ones_cnt_reg == 3'd6) begin
            // Stuffed bit position: must decode as 0 and is dropped.
            if (decoded) begin
              state_next    = ST_ERR;
              rx_err_next   = 1'b1;
              se0_seen_next = 1'b0;
            end else begin
              ones_cnt_next = 3'd0;
            end
          end else begin
            byte_next     = {decoded, byte_reg[7:1]};
            ones_cnt_next = decoded ? ones_cnt_reg + 3'd1 : 3'd0;
            bit_cnt_next  = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              rx_valid_next = 1'b1;
              rx_data_next  = {decoded, byte_reg[7:1]};
            end
          end
        end
        ST_EOP: begin
          if (line_state_reg == LS_J) begin
            state_next     = ST_IDLE;
            rx_active_next = 1'b0;
          end
        end
        ST_ERR: begin
          if (line_state_reg == LS_SE0) begin
            se0_seen_next = 1'b1;
          end else if (line_state_reg == LS_J && se0_seen_reg) begin
            state_next     = ST_IDLE;
            rx_active_next = 1'b0;
          end
        end
        default: begin
          state_next     = ST_IDLE;
          rx_active_next = 1'b0;
        end
      endcase
    end
  end

`ifdef USB_RX_BUS_RESET_EN
  localparam int RW = $clog2(RESET_CYC + 1);
  localparam logic [RW-1:0] RESET_MAX = RW'(RESET_CYC);

  logic [RW-1:0] se0_cnt_reg, se0_cnt_next;
  logic          bus_reset_reg;

  always_comb begin
    se0_cnt_next = '0;
    if (line_state_reg == LS_SE0) begin
      se0_cnt_next = (se0_cnt_reg == RESET_MAX) ? RESET_MAX : se0_cnt_reg + RW'(1);
    end
  end

  always_ff @(posedge clk_48m) begin
    if (!rst_n) begin
      se0_cnt_reg   <= '0;
      bus_reset_reg <= 1'b0;
    end else begin
      se0_cnt_reg   <= se0_cnt_next;
      bus_reset_reg <= (se0_cnt_next == RESET_MAX);
    end
  end

  assign bus_reset = bus_reset_reg;
`else
  logic unused_reset_cyc;
  assign unused_reset_cyc = (RESET_CYC > 0);
  assign bus_reset        = 1'b0;
`endif

  assign line_state = line_state_reg;
  assign rx_active  = rx_active_reg;
  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign rx_err     = rx_err_reg;

endmodule

// File: tb/tb_usb_phy_rx.sv
// Scoreboard bench for usb_phy_rx: directed packets are NRZI-encoded here, expected
// strobes queued on issue, and a negedge monitor pops and compares each DUT strobe.
module tb_usb_phy_rx;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clk_48m = 1'b0;
  logic       rst_n;
  logic       usb_dp_rx, usb_dn_rx;
  logic       rx_en;
  logic [1:0] line_state;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       bus_reset;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         valid_cnt = 0;
  logic [1:0] cur = 2'b10;
  bit         jit = 1'b0;
  bit         tog = 1'b0;
  bit         chk_rise = 1'b0;
  int         ones = 0;

  usb_phy_rx dut (
    .clk_48m   (clk_48m),
    .rst_n     (rst_n),
    .usb_dp_rx (usb_dp_rx),
    .usb_dn_rx (usb_dn_rx),
    .rx_en     (rx_en),
    .line_state(line_state),
    .rx_active (rx_active),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .bus_reset (bus_reset)
  );

  always #5 clk_48m = ~clk_48m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_48m);
    #1;
  endtask

  task automatic drive(input logic [1:0] lv, input int n);
    {usb_dp_rx, usb_dn_rx} = lv;
    tick(n);
  endtask

  task automatic send_bit(input bit b);
    int per;
    if (!b) cur = (cur == J) ? K : J;
    per = jit ? (tog ? 5 : 3) : 4;
    tog = ~tog;
    {usb_dp_rx, usb_dn_rx} = cur;
    if (chk_rise) begin
      chk_rise = 1'b0;
      tick(1);
      check("active_rise", {31'd0, rx_active}, 32'd1);
      tick(per - 1);
    end else begin
      tick(per);
    end
  endtask

  task automatic send_sync(input bit check_rise);
    cur = J;
    tog = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
    ones = 0;
    if (check_rise) begin
      check("active_pre", {31'd0, rx_active}, 32'd0);
      chk_rise = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit push);
    if (push) exp_q.push_back('{1'b0, d});
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      ones = d[i] ? ones + 1 : 0;
      if (ones == 6) begin
        send_bit(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic send_eop();
    drive(SE0, 8);
    cur = J;
    {usb_dp_rx, usb_dn_rx} = J;
  endtask

  // J has just been driven; rx_active must drop within the DPLL sampling window.
  task automatic wait_active_low(input string name);
    int n;
    n = 0;
    while (n < 20 && rx_active) begin
      tick(1);
      n++;
    end
    checks++;
    if (n < 3 || n > 6) begin
      errors++;
      $display("FAIL %s cycles_to_fall actual=%0d required=3..6", name, n);
    end else begin
      $display("ok   %s fell after %0d cycles", name, n);
    end
    drive(J, 12);
  endtask

  always @(negedge clk_48m) begin
    if (rst_n === 1'b1 && (rx_valid === 1'b1 || rx_err === 1'b1)) begin
      checks++;
      if (rx_valid && rx_err) begin
        errors++;
        $display("FAIL strobe_overlap actual=valid+err required=one_of");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe actual valid=%0b err=%0b data=%h required=none",
                 rx_valid, rx_err, rx_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_err != rx_err || (rx_valid && (rx_data != e.data || !rx_active))) begin
          errors++;
          $display("FAIL rx_strobe actual err=%0b data=%h active=%0b required err=%0b data=%h active=1",
                   rx_err, rx_data, rx_active, e.is_err, e.data);
        end else if (rx_valid) begin
          $display("ok   rx_valid data=%h", rx_data);
        end else begin
          $display("ok   rx_err strobe");
        end
      end
      if (rx_valid) valid_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    rx_en = 1'b0;
    {usb_dp_rx, usb_dn_rx} = K;
    repeat (3) @(posedge clk_48m);
    #1;
    check("reset_line_state", {30'd0, line_state}, 32'd0);
    check("reset_strobes_active_busrst", {28'd0, rx_active, rx_valid, rx_err, bus_reset}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("ls_release_1", {30'd0, line_state}, 32'd0);
    tick(1);
    check("ls_release_2", {30'd0, line_state}, 32'h1);
    drive(J, 16);
    rx_en = 1'b1;
    drive(J, 8);

    // ACK packet
    jit = 1'b0;
    send_sync(1'b1);
    send_byte(8'hD2, 1'b1);
    send_eop();
    wait_active_low("ack_eop");

    // Bit stuffing across 0xFF then 0x01
    send_sync(1'b0);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    send_eop();
    wait_active_low("stuff_eop");

    // Stuff error: seven consecutive ones
    send_sync(1'b0);
    exp_q.push_back('{1'b1, 8'h00});
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    send_eop();
    wait_active_low("stufferr_eop");

    // Jitter: 3/5 clock bit periods
    jit = 1'b1;
    base = valid_cnt;
    send_sync(1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'hA5, 1'b1);
    send_eop();
    wait_active_low("jitter_eop");
    check("jitter_count", valid_cnt - base, 32'd8);

    // Abort: rx_en dropped after third byte
    base = valid_cnt;
    fork
      begin
        send_sync(1'b0);
        for (int i = 0; i < 8; i++) send_byte(8'hA5, i < 3);
        send_eop();
        drive(J, 8);
      end
      begin
        int n;
        n = 0;
        while (n < 400 && valid_cnt - base < 3) begin
          tick(1);
          n++;
        end
        if (valid_cnt - base < 3) begin
          checks++;
          errors++;
          $display("FAIL abort_wait actual=%0d bytes required=3", valid_cnt - base);
        end
        rx_en = 1'b0;
        tick(1);
        check("abort_active_low", {31'd0, rx_active}, 32'd0);
      end
    join
    check("abort_count", valid_cnt - base, 32'd3);
    rx_en = 1'b1;
    jit = 1'b0;
    drive(J, 8);

    // Bus reset: 130 clocks of SE0
    {usb_dp_rx, usb_dn_rx} = SE0;
    tick(121);
    check("busrst_before", {31'd0, bus_reset}, 32'd0);
    tick(1);
`ifdef USB_RX_BUS_RESET_EN
    check("busrst_rise", {31'd0, bus_reset}, 32'd1);
`else
    check("busrst_absent", {31'd0, bus_reset}, 32'd0);
`endif
    tick(8);
    {usb_dp_rx, usb_dn_rx} = J;
    tick(2);
`ifdef USB_RX_BUS_RESET_EN
    check("busrst_hold", {31'd0, bus_reset}, 32'd1);
`else
    check("busrst_absent_hold", {31'd0, bus_reset}, 32'd0);
`endif
    tick(1);
    check("busrst_fall", {31'd0, bus_reset}, 32'd0);
    drive(J, 8);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
